// File: rtl/serial_pattern_sched.sv
// serial_pattern_sched: valid/ready word serializer feeding a Mealy pattern detector, returning per-word match count and mask
module serial_pattern_sched #(
  parameter int WORD_W = 8,
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic [PAT_W-1:0]  pattern,
  input  logic              overlap,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  match_count,
  output logic [WORD_W-1:0] match_mask,
  output logic              busy,
  output logic              det_x,
  output logic              det_y
);
  localparam int FW = $clog2(PAT_W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;
  state_t state, state_n;
  logic [WORD_W-1:0] data_q, bit_ptr;
  logic [PAT_W-1:0] pat_q, cand;
  logic [PAT_W-2:0] window;
  logic ovl_q;
  logic [FW-1:0] fill, fill_n;
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == REPORT;
    busy = state != IDLE;
    det_x = state == SHIFT ? data_q[WORD_W-1] : 1'b0;
    cand = {window, det_x};
    det_y = state == SHIFT && fill >= FW'(PAT_W - 1) && cand == pat_q;
    fill_n = det_y && !ovl_q ? '0 : fill == FW'(PAT_W) ? fill : fill + 1'b1;
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = SHIFT;
      SHIFT:   if (bit_ptr[0]) state_n = REPORT;
      REPORT:  if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      data_q <= '0;
      bit_ptr <= '0;
      pat_q <= '0;
      ovl_q <= 1'b0;
      window <= '0;
      fill <= '0;
      match_count <= '0;
      match_mask <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        data_q <= in_data;
        pat_q <= pattern;
        ovl_q <= overlap;
        window <= '0;
        fill <= '0;
        match_count <= '0;
        match_mask <= '0;
        bit_ptr <= {1'b1, {(WORD_W-1){1'b0}}};
      end else if (state == SHIFT) begin
        data_q <= data_q << 1;
        bit_ptr <= bit_ptr >> 1;
        window <= cand[PAT_W-2:0];
        fill <= fill_n;
        if (det_y) begin
          match_mask <= match_mask | bit_ptr;
          match_count <= match_count == '1 ? match_count : match_count + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_pattern_sched.sv
// tb_serial_pattern_sched: directed and random words checked against a window-scan reference model
module tb_serial_pattern_sched;
  localparam int WORD_W = 8;
  localparam int PAT_W = 4;
  localparam int CNT_W = 2;
  logic clk = 0;
  logic reset = 1;
  logic in_valid = 0;
  logic out_ready = 0;
  logic overlap = 0;
  logic [WORD_W-1:0] in_data = '0;
  logic [PAT_W-1:0] pattern = '0;
  logic in_ready, out_valid, busy, det_x, det_y;
  logic [CNT_W-1:0] match_count;
  logic [WORD_W-1:0] match_mask;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  serial_pattern_sched #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .pattern(pattern), .overlap(overlap),
    .out_valid(out_valid), .out_ready(out_ready), .match_count(match_count),
    .match_mask(match_mask), .busy(busy), .det_x(det_x), .det_y(det_y)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [WORD_W-1:0] w, input logic [PAT_W-1:0] p, input logic o,
                                output int cnt, output logic [WORD_W-1:0] m);
    int last;
    last = WORD_W;
    cnt = 0;
    m = '0;
    for (int i = WORD_W - PAT_W; i >= 0; i--)
      if ((o || i + PAT_W - 1 < last) && ((int'(w) >> i) & ((1 << PAT_W) - 1)) == int'(p)) begin
        m[i] = 1'b1;
        cnt = cnt < (1 << CNT_W) - 1 ? cnt + 1 : cnt;
        last = i;
      end
  endfunction
  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_count"}, match_count, 0);
    check({tag, "_mask"}, match_mask, 0);
    check({tag, "_det_x"}, det_x, 0);
  endtask
  task automatic run_word(input logic [WORD_W-1:0] w, input logic [PAT_W-1:0] p, input logic o,
                          input int hold, input int rst_at);
    int ec, t;
    logic [WORD_W-1:0] em, dy;
    model(w, p, o, ec, em);
    @(negedge clk);
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_idle", in_ready, 1);
    in_valid = 1;
    in_data = w;
    pattern = p;
    overlap = o;
    out_ready = 0;
    dy = '0;
    for (int k = 1; k <= WORD_W; k++) begin
      @(negedge clk);
      in_data = WORD_W'($urandom);
      pattern = PAT_W'($urandom);
      overlap = 1'($urandom);
      in_valid = 1'($urandom);
      if (k == rst_at) begin
        reset = 0;
        #1;
        check_reset_vals("midreset");
        @(negedge clk);
        reset = 1;
        in_valid = 0;
        return;
      end
      check("det_x", det_x, w[WORD_W-k]);
      check("in_ready_shift", in_ready, 0);
      check("out_valid_early", out_valid, 0);
      check("busy_shift", busy, 1);
      dy[WORD_W-k] = det_y;
    end
    @(negedge clk);
    check("out_valid", out_valid, 1);
    check("det_y_trace", dy, em);
    check("count", match_count, ec);
    check("mask", match_mask, em);
    in_valid = 1;
    in_data = '1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_count", match_count, ec);
      check("hold_mask", match_mask, em);
    end
    out_ready = 1;
    @(negedge clk);
    check("idle_out_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);
    check("idle_busy", busy, 0);
    check("kept_count", match_count, ec);
    check("kept_mask", match_mask, em);
    in_valid = 0;
    out_ready = 0;
  endtask
  initial begin
    #2 reset = 0;
    #1 check_reset_vals("reset");
    @(negedge clk);
    reset = 1;
    run_word(8'b1001_0010, 4'b1001, 1, 0, 0);
    run_word(8'b1001_0010, 4'b1001, 0, 0, 0);
    run_word(8'b1011_0110, 4'b1011, 1, 0, 0);
    run_word(8'b1011_0110, 4'b1011, 0, 0, 0);
    run_word(8'h00, 4'b0000, 1, 0, 0);
    run_word(8'b1001_0010, 4'b1001, 1, 3, 0);
    run_word(8'b1001_1001, 4'b1001, 1, 0, 5);
    run_word(8'b1001_1001, 4'b1001, 1, 0, 0);
    for (int n = 0; n < 60; n++)
      run_word(WORD_W'($urandom_range(0, 255) & ($urandom_range(0, 1) ? 8'hFF : 8'h99)),
               PAT_W'($urandom_range(0, 15)), 1'($urandom), $urandom_range(0, 2),
               $urandom_range(0, 9) == 0 ? $urandom_range(1, WORD_W) : 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
